// File: rtl/md_pad6.sv
// Six-button controller pad emulation: tracks TH handshake phases from the
// console port and presents the matching active-low button row on the data pins.
module md_pad6 #(
    parameter int SIX_BUTTON = 1,
    parameter int TIMEOUT    = 86000
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [6:0]  PORT_i,
    input  logic [6:0]  PORT_d,
    input  logic [11:0] BTN,
    output logic [6:0]  PAD_o,
    output logic [6:0]  PAD_d,
    output logic [2:0]  PHASE
);

    localparam logic [16:0] IDLE_MAX = 17'(TIMEOUT);

    logic        th_eff_s;
    logic        sync0_q;
    logic        sync1_q;
    logic        th_edge_s;
    logic        timeout_s;
    logic [2:0]  phase_q;
    logic [2:0]  phase_d;
    logic [16:0] idle_q;
    logic [16:0] idle_d;
    logic [11:0] btn_n_s;
    logic [5:0]  row_s;
    logic [6:0]  pad_q;
    logic [6:0]  pad_d;
    logic        unused_s;

    // An undriven TH line floats high through the console pull-up.
    assign th_eff_s  = PORT_d[6] ? 1'b1 : PORT_i[6];
    assign th_edge_s = sync0_q ^ sync1_q;
    assign timeout_s = (idle_q == IDLE_MAX);
    assign btn_n_s   = ~BTN;
    assign unused_s  = ^{PORT_i[5:0], PORT_d[5:0]};

    // TH synchronizer; the older stage doubles as the previous level for edge detection.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            sync0_q <= 1'b1;
            sync1_q <= 1'b1;
        end else begin
            sync0_q <= th_eff_s;
            sync1_q <= sync0_q;
        end
    end

    // Phase advance and idle timeout; an edge beats a coincident timeout.
    always_comb begin
        phase_d = phase_q;
        idle_d  = idle_q;
        if (th_edge_s) begin
            idle_d = 17'd0;
            if (SIX_BUTTON != 0) begin
                phase_d = phase_q + 3'd1;
            end else begin
                phase_d = 3'd0;
            end
        end else if (timeout_s) begin
            phase_d = 3'd0;
        end else begin
            idle_d = idle_q + 17'd1;
        end
    end

    // Phase and idle counter registers.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= 3'd0;
            idle_q  <= 17'd0;
        end else begin
            phase_q <= phase_d;
            idle_q  <= idle_d;
        end
    end

    // Row select: TH level picks the half, phase picks the extended rows.
    always_comb begin
        row_s = {btn_n_s[6], btn_n_s[5], btn_n_s[3], btn_n_s[2], btn_n_s[1], btn_n_s[0]};
        if (sync1_q) begin
            if (phase_q == 3'd6) begin
                row_s = {1'b1, 1'b1, btn_n_s[11], btn_n_s[8], btn_n_s[9], btn_n_s[10]};
            end else begin
                row_s = {btn_n_s[6], btn_n_s[5], btn_n_s[3], btn_n_s[2], btn_n_s[1], btn_n_s[0]};
            end
        end else begin
            case (phase_q)
                3'd5:    row_s = {btn_n_s[7], btn_n_s[4], 4'b0000};
                3'd7:    row_s = {btn_n_s[7], btn_n_s[4], 4'b1111};
                default: row_s = {btn_n_s[7], btn_n_s[4], 2'b00, btn_n_s[1], btn_n_s[0]};
            endcase
        end
        pad_d = {1'b1, row_s};
    end

    // Output flop; reset presents all buttons released.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            pad_q <= 7'h7F;
        end else begin
            pad_q <= pad_d;
        end
    end

    assign PAD_o = pad_q;
    assign PAD_d = 7'b1000000;
    assign PHASE = phase_q;

endmodule

// File: tb/tb_md_pad6.sv
// Bench for md_pad6: six- and three-button instances against a cycle model
// derived from the handshake rules, with directed steps and a random phase.
module tb_md_pad6;

    localparam int TMO = 40;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic [6:0]  PORT_i;
    logic [6:0]  PORT_d;
    logic [11:0] BTN;
    logic [6:0]  pad6, padd6, pad3, padd3;
    logic [2:0]  ph6, ph3;

    int errors = 0;
    int checks = 0;

    // model state
    int         cyc;
    int         last_evt;
    int         m_phase;
    logic       th_h1, th_h2;
    logic [6:0] m_pad6, m_pad3;

    always #5 MCLK = ~MCLK;

    md_pad6 #(.SIX_BUTTON(1), .TIMEOUT(TMO)) dut6 (
        .MCLK(MCLK), .RESET(RESET), .PORT_i(PORT_i), .PORT_d(PORT_d),
        .BTN(BTN), .PAD_o(pad6), .PAD_d(padd6), .PHASE(ph6));

    md_pad6 #(.SIX_BUTTON(0), .TIMEOUT(TMO)) dut3 (
        .MCLK(MCLK), .RESET(RESET), .PORT_i(PORT_i), .PORT_d(PORT_d),
        .BTN(BTN), .PAD_o(pad3), .PAD_d(padd3), .PHASE(ph3));

    function automatic logic [6:0] row(input int ph, input logic th, input logic [11:0] b);
        logic [11:0] n;
        n = ~b;
        if (th) begin
            if (ph == 6) row = {1'b1, 1'b1, 1'b1, n[11], n[8], n[9], n[10]};
            else         row = {1'b1, n[6], n[5], n[3], n[2], n[1], n[0]};
        end else if (ph == 5) row = {1'b1, n[7], n[4], 4'b0000};
        else if (ph == 7)     row = {1'b1, n[7], n[4], 4'b1111};
        else                  row = {1'b1, n[7], n[4], 2'b00, n[1], n[0]};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        th_h1    = 1'b1;
        th_h2    = 1'b1;
        last_evt = cyc;
        m_pad6   = 7'h7F;
        m_pad3   = 7'h7F;
    endtask

    task automatic check_all();
        chk("pad6", pad6, m_pad6);
        chk("phase6", {4'd0, ph6}, 7'(m_phase));
        chk("pad3", pad3, m_pad3);
        chk("phase3", {4'd0, ph3}, 7'd0);
        chk("dir6", padd6, 7'h40);
        chk("dir3", padd3, 7'h40);
    endtask

    task automatic step();
        logic th_now;
        th_now = (PORT_d[6] == 1'b1) || (PORT_i[6] == 1'b1);
        @(posedge MCLK);
        cyc++;
        if (RESET) begin
            model_reset();
        end else begin
            m_pad6 = row(m_phase, th_h2, BTN);
            m_pad3 = row(0, th_h2, BTN);
            if (th_h1 != th_h2) begin
                m_phase  = (m_phase + 1) % 8;
                last_evt = cyc;
            end else if (cyc - 1 - last_evt >= TMO) begin
                m_phase = 0;
            end
            th_h2 = th_h1;
            th_h1 = th_now;
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic toggle_th();
        PORT_i[6] = ~PORT_i[6];
    endtask

    initial begin
        RESET  = 1'b0;
        PORT_i = 7'h7F;
        PORT_d = 7'h00;
        BTN    = 12'h041;
        cyc    = 0;
        model_reset();
        #1 RESET = 1'b1;
        #1;
        check_all();
        steps(3);
        RESET = 1'b0;
        steps(4);
        chk("idle_pad", pad6, 7'h5E);
        chk("idle_phase", {4'd0, ph6}, 7'h00);

        // full handshake with wrap
        BTN = 12'h910;
        for (int i = 0; i < 8; i++) begin
            toggle_th();
            steps(20);
            chk("hs_phase", {4'd0, ph6}, 7'((i + 1) % 8));
            if (i == 4) chk("hs_p5_low", {3'd0, pad6[3:0]}, 7'h00);
            if (i == 5) chk("hs_p6", pad6, row(6, 1'b1, BTN));
            if (i == 6) chk("hs_p7", pad6, 7'h6F);
        end

        // timeout after three edges
        for (int i = 0; i < 3; i++) begin
            toggle_th();
            steps(10);
        end
        steps(TMO + 2);
        chk("tmo_phase", {4'd0, ph6}, 7'h00);
        toggle_th();
        steps(3);
        chk("tmo_next", {4'd0, ph6}, 7'h01);

        // edge coinciding with timeout
        toggle_th();
        steps(2);
        steps(TMO - 1);
        toggle_th();
        steps(2);
        chk("simul_phase", {4'd0, ph6}, 7'h03);
        steps(TMO + 3);

        // direction masking and latency
        PORT_i[6] = 1'b0;
        PORT_d[6] = 1'b1;
        steps(5);
        chk("dir_noedge", {4'd0, ph6}, 7'h00);
        PORT_d[6] = 1'b0;
        step();
        chk("lat_c1", {4'd0, ph6}, 7'h00);
        step();
        chk("lat_c2_phase", {4'd0, ph6}, 7'h01);
        chk("lat_c2_pad", pad6, row(0, 1'b1, BTN));
        step();
        chk("lat_c3_pad", pad6, row(1, 1'b0, BTN));

        // three-button alternation
        BTN = 12'h0F5;
        for (int i = 0; i < 10; i++) begin
            toggle_th();
            steps(5);
            chk("b3_phase", {4'd0, ph3}, 7'h00);
            chk("b3_row", pad3, row(0, PORT_i[6], BTN));
        end

        // reset in phase 6
        for (int i = 0; i < 8; i++) begin
            if (m_phase != 6) begin
                toggle_th();
                steps(5);
            end
        end
        chk("pre_rst_p6", {4'd0, ph6}, 7'h06);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk("rst_pad6", pad6, 7'h7F);
        chk("rst_phase6", {4'd0, ph6}, 7'h00);
        chk("rst_pad3", pad3, 7'h7F);
        steps(2);
        RESET = 1'b0;
        steps(4);

        // randomized handshakes, direction flips and button changes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) toggle_th();
            if ($urandom_range(0, 31) == 0) PORT_d[6] = ~PORT_d[6];
            if ($urandom_range(0, 3) == 0) BTN = 12'($urandom);
            if ($urandom_range(0, 99) == 0) steps(TMO + $urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
